// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues single-outstanding imem requests and
// hands fetched instructions to decode, applying trap/branch redirects.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_branch_enable,
  input  logic [31:0] i_branch_target,
  input  logic        i_trap_enable,
  input  logic [31:0] i_trap_target,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_resp_valid,
  input  logic [31:0] i_imem_resp_data,
  output logic        o_if_valid,
  input  logic        i_if_ready,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_instr,
  output logic [31:0] o_pc_out
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic        r_discard;
  logic        r_if_valid;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_instr;

  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_req_fire;
  logic        w_if_fire;

  // Trap wins over branch; targets are forced word-aligned.
  assign w_redirect = i_trap_enable | i_branch_enable;
  assign w_target   = (i_trap_enable ? i_trap_target : i_branch_target) & 32'hFFFF_FFFC;

  assign o_imem_req_valid = (r_state == S_REQ) & ~rst;
  assign o_imem_req_addr  = r_pc;
  assign w_req_fire       = o_imem_req_valid & i_imem_req_ready;
  assign w_if_fire        = r_if_valid & i_if_ready;

  assign o_if_valid = r_if_valid;
  assign o_if_pc    = r_if_pc;
  assign o_if_instr = r_if_instr;
  assign o_pc_out   = r_pc;

  // Sequencer state, PC and the decode-facing holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_discard  <= 1'b0;
      r_if_valid <= 1'b0;
      r_if_pc    <= 32'h0000_0000;
      r_if_instr <= 32'h0000_0000;
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_redirect) begin
            r_pc <= w_target;
            if (w_req_fire) begin
              // The request just issued carries the old PC; its reply is stale.
              r_state   <= S_WAIT;
              r_discard <= 1'b1;
            end else begin
              r_state <= S_REQ;
            end
          end else if (w_req_fire) begin
            r_state <= S_WAIT;
          end else begin
            r_state <= S_REQ;
          end
        end
        S_WAIT: begin
          if (i_imem_resp_valid) begin
            if (r_discard | w_redirect) begin
              r_discard <= 1'b0;
              r_state   <= S_REQ;
            end else begin
              r_if_pc    <= r_pc;
              r_if_instr <= i_imem_resp_data;
              r_if_valid <= 1'b1;
              r_state    <= S_HOLD;
            end
            if (w_redirect) begin
              r_pc <= w_target;
            end else begin
              r_pc <= r_pc;
            end
          end else if (w_redirect) begin
            r_pc      <= w_target;
            r_discard <= 1'b1;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_HOLD: begin
          if (w_redirect) begin
            r_if_valid <= 1'b0;
            r_pc       <= w_target;
            r_state    <= S_REQ;
          end else if (w_if_fire) begin
            r_if_valid <= 1'b0;
            r_pc       <= r_pc + 32'd4;
            r_state    <= S_REQ;
          end else begin
            r_state <= S_HOLD;
          end
        end
        default: begin
          r_state    <= S_REQ;
          r_discard  <= 1'b0;
          r_if_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer that owns the program counter and drives it against the instruction memory through a single-outstanding request/response port. It delivers fetched instructions to decode through a valid/ready handshake. It also applies redirects from execute (branch) and the trap unit, discarding any fetch already in flight when a redirect lands. It sits between the PC register function, imem, and the decode stage.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded by reset.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high. imem is reset by the same rst.
- branch_enable  in  1  branch/jump redirect request from execute.
- branch_target  in  32  branch destination.
- trap_enable  in  1  trap redirect request; has priority over branch_enable.
- trap_target  in  32  trap vector address.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  imem accepts request.
- imem_req_addr  out  32  fetch address (equals pc_out).
- imem_resp_valid  in  1  response data valid; at most one per accepted request, earliest the cycle after accept.
- imem_resp_data  in  32  instruction word.
- if_valid  out  1  instruction available to decode.
- if_ready  in  1  decode accepts instruction.
- if_pc  out  32  PC of the presented instruction.
- if_instr  out  32  presented instruction word.
- pc_out  out  32  current fetch PC.

## Operation
- State machine with three states. Reset state is REQ.
  - REQ: imem_req_valid=1, addr=pc. On req_valid&req_ready, go to WAIT.
  - WAIT: waiting for the response. On resp_valid with discard=0: capture if_pc=pc and if_instr=data, then go to HOLD. On resp_valid with discard=1: drop the data, clear discard, go to REQ.
  - HOLD: if_valid=1, if_pc and if_instr stable. On if_valid&if_ready: pc <= pc+4 (mod 2^32) and go to REQ.
- Redirect target selection:
  - trap_enable uses trap_target.
  - Otherwise, branch_enable uses branch_target.
  - Target bits [1:0] are forced to 0.
- Redirect handling by state (a redirect always loads pc <= target):
  - REQ, request not accepted the same cycle: stay in REQ.
  - REQ, request accepted the same cycle: go to WAIT with discard=1.
  - WAIT: set discard=1 and stay in WAIT. If resp_valid arrives in the same cycle, drop that response and go to REQ.
  - HOLD: drop the held instruction (if_valid=0 next cycle) and go to REQ. A redirect overrides an if handshake in the same cycle; the instruction still counts as consumed by decode, and pc takes the target, not pc+4.
- imem_resp_valid is ignored in REQ and HOLD.
- Reset values:
  - pc_out = RESET_PC, state = REQ, discard = 0.
  - if_valid = 0, if_pc = 0, if_instr = 0.
  - imem_req_valid is gated to 0 while rst=1.

## Timing
- The cycle after rst deasserts, imem_req_valid=1 and addr=RESET_PC.
- Best-case throughput with a 1-cycle imem:
  - Request accepted in cycle N, response in N+1.
  - if_valid in N+2. With if_ready=1, the handshake completes in N+2.
  - Next request in N+3, i.e. one instruction per 3 cycles.
- Redirect in cycle N:
  - From REQ or HOLD: imem_req_addr = target in N+1.
  - From WAIT: the new request is issued the cycle after the stale response arrives.
- imem_req_addr, if_pc and if_instr must not change while their valid is high and not yet accepted, except on a redirect.
- rst asserted in any state:
  - Next cycle: state REQ, all outputs at reset values, discard cleared.
  - No pending response survives, because imem is reset too.

## Test plan
- Reset: hold rst 2 cycles with RESET_PC=32'h100, then release. Response required: req_valid=0 during rst; req at 0x100 the first cycle after release. With imem returning 0x00000013 and if_ready=1, decode sees pc 0x100, 0x104, 0x108 at 3-cycle spacing.
- Backpressure: imem_req_ready low 4 cycles, then if_ready low 5 cycles. Response required: req_addr stable while unaccepted; if_valid, if_pc and if_instr stable while unaccepted; no PC advance until the handshake.
- Redirect in WAIT: branch_target 0x200 asserted while a 0x108 fetch is outstanding, response arriving 3 cycles later. Response required: that response is dropped with no if_valid; the next request is at 0x200.
- Simultaneous events:
  - branch to 0x300 and trap to 0x80 in the same cycle: pc becomes 0x80.
  - A redirect in HOLD coinciding with if_ready: pc becomes the target, not pc+4.
- Misaligned target and wrap:
  - branch_target 0x203: request goes to 0x200.
  - PC 0xFFFF_FFFC after a handshake: next request goes to 0x0.
- Reset mid-WAIT: assert rst with a fetch outstanding. Response required: if_valid=0; after release, a request at RESET_PC; no stale instruction delivered.
